// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage memory access controller.
package mem_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [3:0] BE_WORD = 4'hF;
    localparam logic [3:0] BE_B0   = 4'h1;
    localparam int DEFAULT_MAX_WAIT = 15;
    localparam int LANES = 4;

    // Bits needed to hold values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_byte_lane_unit.sv
// Byte-lane steering: store byte enables and lane replication, load byte
// extraction with zero extension (little-endian lane numbering).
module byte_lane_unit
    import mem_ctrl_pkg::*;
(
    input  logic        st_byte,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    input  logic        ld_byte,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_data,
    output logic [3:0]  be,
    output logic [31:0] st_lanes,
    output logic [31:0] ld_result
);

    logic [7:0] ld_lane [LANES];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign st_lanes[8*gi +: 8] = st_byte ? st_data[7:0] : st_data[8*gi +: 8];
            assign ld_lane[gi]         = ld_data[8*gi +: 8];
        end
    endgenerate

    assign be        = st_byte ? (BE_B0 << st_off) : BE_WORD;
    assign ld_result = ld_byte ? {24'd0, ld_lane[ld_off]} : ld_data;

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: issues data-memory accesses over req/ack, stalls the
// upstream stages while an access is outstanding, drives MEM/WB registers.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exe_valid,
    input  logic              EXE_ReadfromMem,
    input  logic              EXE_WritetoMem,
    input  logic              EXE_R_memtoReg,
    input  logic              exe_byte,
    input  logic              exe_regwrite,
    input  logic [REG_W-1:0]  exe_rd,
    input  logic [ADDR_W-1:0] exe_addr,
    input  logic [DATA_W-1:0] exe_wdata,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              wb_regwrite,
    output logic              wb_memtoReg,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_alu,
    output logic [DATA_W-1:0] wb_mdata,
    output logic              mem_err
);

    localparam int CNT_W = clog2(MAX_WAIT + 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              mem_req_reg, mem_req_next;
    logic              mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [3:0]        mem_be_reg, mem_be_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic              wb_valid_reg, wb_valid_next;
    logic              wb_regwrite_reg, wb_regwrite_next;
    logic              wb_memtoreg_reg, wb_memtoreg_next;
    logic [REG_W-1:0]  wb_rd_reg, wb_rd_next;
    logic [DATA_W-1:0] wb_alu_reg, wb_alu_next;
    logic [DATA_W-1:0] wb_mdata_reg, wb_mdata_next;
    logic              mem_err_reg, mem_err_next;
    // Instruction context held while the access is outstanding.
    logic              cap_regwrite_reg, cap_regwrite_next;
    logic              cap_memtoreg_reg, cap_memtoreg_next;
    logic              cap_byte_reg, cap_byte_next;
    logic [REG_W-1:0]  cap_rd_reg, cap_rd_next;
    logic [ADDR_W-1:0] cap_addr_reg, cap_addr_next;

    logic [3:0]        lane_be;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_rdata;
    logic              is_mem_op;
    logic              is_bad_op;

    byte_lane_unit u_lanes (
        .st_byte   (exe_byte),
        .st_off    (exe_addr[1:0]),
        .st_data   (exe_wdata),
        .ld_byte   (cap_byte_reg),
        .ld_off    (cap_addr_reg[1:0]),
        .ld_data   (mem_rdata),
        .be        (lane_be),
        .st_lanes  (lane_wdata),
        .ld_result (lane_rdata)
    );

    // Read+write together is as illegal as an unaligned word access.
    assign is_mem_op = EXE_ReadfromMem | EXE_WritetoMem;
    assign is_bad_op = (EXE_ReadfromMem & EXE_WritetoMem) |
                       (is_mem_op & ~exe_byte & (exe_addr[1:0] != 2'b00));

    // Next-state and registered-output logic; pulses default low, rest hold.
    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        mem_req_next      = mem_req_reg;
        mem_we_next       = mem_we_reg;
        mem_addr_next     = mem_addr_reg;
        mem_be_next       = mem_be_reg;
        mem_wdata_next    = mem_wdata_reg;
        wb_valid_next     = 1'b0;
        wb_regwrite_next  = wb_regwrite_reg;
        wb_memtoreg_next  = wb_memtoreg_reg;
        wb_rd_next        = wb_rd_reg;
        wb_alu_next       = wb_alu_reg;
        wb_mdata_next     = wb_mdata_reg;
        mem_err_next      = 1'b0;
        cap_regwrite_next = cap_regwrite_reg;
        cap_memtoreg_next = cap_memtoreg_reg;
        cap_byte_next     = cap_byte_reg;
        cap_rd_next       = cap_rd_reg;
        cap_addr_next     = cap_addr_reg;
        case (state_reg)
            IDLE: begin
                if (exe_valid) begin
                    if (!is_mem_op || is_bad_op) begin
                        wb_valid_next    = 1'b1;
                        wb_regwrite_next = is_bad_op ? 1'b0 : exe_regwrite;
                        wb_memtoreg_next = is_bad_op ? EXE_R_memtoReg : 1'b0;
                        wb_rd_next       = exe_rd;
                        wb_alu_next      = DATA_W'(exe_addr);
                        mem_err_next     = is_bad_op;
                    end else begin
                        state_next        = WAIT;
                        cnt_next          = '0;
                        mem_req_next      = 1'b1;
                        mem_we_next       = EXE_WritetoMem;
                        mem_addr_next     = {exe_addr[ADDR_W-1:2], 2'b00};
                        mem_be_next       = lane_be;
                        mem_wdata_next    = lane_wdata;
                        cap_regwrite_next = exe_regwrite;
                        cap_memtoreg_next = EXE_R_memtoReg;
                        cap_byte_next     = exe_byte;
                        cap_rd_next       = exe_rd;
                        cap_addr_next     = exe_addr;
                    end
                end
            end
            WAIT: begin
                if (mem_ack || (cnt_reg == CNT_W'(MAX_WAIT - 1))) begin
                    // Ack has priority over an expiring counter.
                    state_next       = IDLE;
                    mem_req_next     = 1'b0;
                    mem_we_next      = 1'b0;
                    wb_valid_next    = 1'b1;
                    wb_regwrite_next = mem_ack & cap_regwrite_reg & ~mem_we_reg;
                    wb_memtoreg_next = cap_memtoreg_reg;
                    wb_rd_next       = cap_rd_reg;
                    wb_alu_next      = DATA_W'(cap_addr_reg);
                    mem_err_next     = ~mem_ack;
                    if (mem_ack && !mem_we_reg) begin
                        wb_mdata_next = lane_rdata;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and pipeline registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            mem_req_reg      <= 1'b0;
            mem_we_reg       <= 1'b0;
            mem_addr_reg     <= '0;
            mem_be_reg       <= '0;
            mem_wdata_reg    <= '0;
            wb_valid_reg     <= 1'b0;
            wb_regwrite_reg  <= 1'b0;
            wb_memtoreg_reg  <= 1'b0;
            wb_rd_reg        <= '0;
            wb_alu_reg       <= '0;
            wb_mdata_reg     <= '0;
            mem_err_reg      <= 1'b0;
            cap_regwrite_reg <= 1'b0;
            cap_memtoreg_reg <= 1'b0;
            cap_byte_reg     <= 1'b0;
            cap_rd_reg       <= '0;
            cap_addr_reg     <= '0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            mem_req_reg      <= mem_req_next;
            mem_we_reg       <= mem_we_next;
            mem_addr_reg     <= mem_addr_next;
            mem_be_reg       <= mem_be_next;
            mem_wdata_reg    <= mem_wdata_next;
            wb_valid_reg     <= wb_valid_next;
            wb_regwrite_reg  <= wb_regwrite_next;
            wb_memtoreg_reg  <= wb_memtoreg_next;
            wb_rd_reg        <= wb_rd_next;
            wb_alu_reg       <= wb_alu_next;
            wb_mdata_reg     <= wb_mdata_next;
            mem_err_reg      <= mem_err_next;
            cap_regwrite_reg <= cap_regwrite_next;
            cap_memtoreg_reg <= cap_memtoreg_next;
            cap_byte_reg     <= cap_byte_next;
            cap_rd_reg       <= cap_rd_next;
            cap_addr_reg     <= cap_addr_next;
        end
    end

    assign stall       = (state_reg == WAIT);
    assign mem_req     = mem_req_reg;
    assign mem_we      = mem_we_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_be      = mem_be_reg;
    assign mem_wdata   = mem_wdata_reg;
    assign wb_valid    = wb_valid_reg;
    assign wb_regwrite = wb_regwrite_reg;
    assign wb_memtoReg = wb_memtoreg_reg;
    assign wb_rd       = wb_rd_reg;
    assign wb_alu      = wb_alu_reg;
    assign wb_mdata    = wb_mdata_reg;
    assign mem_err     = mem_err_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl against a transaction-level model.
module tb_mem_access_ctrl;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        exe_valid, EXE_ReadfromMem, EXE_WritetoMem, EXE_R_memtoReg;
    logic        exe_byte, exe_regwrite;
    logic [4:0]  exe_rd;
    logic [31:0] exe_addr, exe_wdata;
    logic        stall, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        wb_valid, wb_regwrite, wb_memtoReg, mem_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_alu, wb_mdata;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .REG_W(5), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .exe_valid(exe_valid),
        .EXE_ReadfromMem(EXE_ReadfromMem), .EXE_WritetoMem(EXE_WritetoMem),
        .EXE_R_memtoReg(EXE_R_memtoReg), .exe_byte(exe_byte),
        .exe_regwrite(exe_regwrite), .exe_rd(exe_rd), .exe_addr(exe_addr),
        .exe_wdata(exe_wdata), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
        .wb_regwrite(wb_regwrite), .wb_memtoReg(wb_memtoReg), .wb_rd(wb_rd),
        .wb_alu(wb_alu), .wb_mdata(wb_mdata), .mem_err(mem_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic scramble_exe();
        EXE_ReadfromMem = 1'($urandom);
        EXE_WritetoMem  = 1'($urandom);
        exe_addr        = $urandom;
        exe_wdata       = $urandom;
        exe_rd          = 5'($urandom);
    endtask

    // One instruction from issue to retire; entered and left at a negedge.
    // d = number of WAIT cycles without ack before ack (d >= MAX_WAIT: never).
    task automatic run_txn(input logic rd_f, input logic wr_f, input logic m2r,
                           input logic byte_f, input logic rw, input logic [4:0] rd,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int d, input logic [31:0] rdata);
        logic bad, timeout;
        logic [31:0] exp_wdata, exp_mdata;
        int n, seen;
        bad = (rd_f && wr_f) || ((rd_f || wr_f) && !byte_f && addr[1:0] != 2'b00);
        check_eq("idle_stall", {31'd0, stall}, 32'd0);
        exe_valid = 1'b1; EXE_ReadfromMem = rd_f; EXE_WritetoMem = wr_f;
        EXE_R_memtoReg = m2r; exe_byte = byte_f; exe_regwrite = rw;
        exe_rd = rd; exe_addr = addr; exe_wdata = wdata;
        @(negedge clk);
        exe_valid = 1'b0;
        scramble_exe();
        if (!rd_f && !wr_f) begin
            $display("[TB] alu rd=%0d alu=%08h", rd, addr);
            check_eq("alu_valid", {31'd0, wb_valid}, 32'd1);
            check_eq("alu_regwrite", {31'd0, wb_regwrite}, {31'd0, rw});
            check_eq("alu_memtoreg", {31'd0, wb_memtoReg}, 32'd0);
            check_eq("alu_rd", {27'd0, wb_rd}, {27'd0, rd});
            check_eq("alu_value", wb_alu, addr);
            check_eq("alu_err_stall_req", {29'd0, mem_err, stall, mem_req}, 32'd0);
        end else if (bad) begin
            $display("[TB] illegal rd=%b wr=%b byte=%b addr=%08h", rd_f, wr_f, byte_f, addr);
            check_eq("bad_valid", {31'd0, wb_valid}, 32'd1);
            check_eq("bad_err", {31'd0, mem_err}, 32'd1);
            check_eq("bad_regwrite", {31'd0, wb_regwrite}, 32'd0);
            check_eq("bad_stall_req", {30'd0, stall, mem_req}, 32'd0);
        end else begin
            exp_wdata = byte_f ? ({24'd0, wdata[7:0]} * 32'h01010101) : wdata;
            check_eq("acc_req", {30'd0, stall, mem_req}, 32'd3);
            check_eq("acc_we", {31'd0, mem_we}, {31'd0, wr_f});
            check_eq("acc_addr", mem_addr, addr & ~32'd3);
            check_eq("acc_be", {28'd0, mem_be}, byte_f ? (32'd1 << addr[1:0]) : 32'd15);
            check_eq("acc_wdata", mem_wdata, exp_wdata);
            check_eq("acc_no_early_wb", {31'd0, wb_valid}, 32'd0);
            timeout = (d >= MAX_WAIT);
            n = timeout ? MAX_WAIT : d + 1;
            seen = 0;
            for (int k = 0; k < n; k++) begin
                if (stall && mem_req && mem_addr == (addr & ~32'd3) && mem_wdata == exp_wdata)
                    seen++;
                mem_ack   = (k == d);
                mem_rdata = (k == d) ? rdata : $urandom;
                @(negedge clk);
            end
            mem_ack = 1'b0;
            $display("[TB] %s %s addr=%08h waits=%0d %s", wr_f ? "store" : "load",
                     byte_f ? "byte" : "word", addr, n, timeout ? "timeout" : "ack");
            check_eq("wait_cycles_held", seen, n);
            check_eq("ret_valid", {31'd0, wb_valid}, 32'd1);
            check_eq("ret_err", {31'd0, mem_err}, {31'd0, timeout});
            check_eq("ret_regwrite", {31'd0, wb_regwrite}, {31'd0, rd_f && !timeout && rw});
            check_eq("ret_stall_req", {30'd0, stall, mem_req}, 32'd0);
            check_eq("ret_memtoreg", {31'd0, wb_memtoReg}, {31'd0, m2r});
            check_eq("ret_rd", {27'd0, wb_rd}, {27'd0, rd});
            check_eq("ret_alu", wb_alu, addr);
            if (rd_f && !timeout) begin
                exp_mdata = byte_f ? ((rdata >> (8 * addr[1:0])) & 32'hFF) : rdata;
                check_eq("ret_mdata", wb_mdata, exp_mdata);
            end
        end
    endtask

    // A bubble cycle: pulses must be gone and a stray ack ignored.
    task automatic idle_cycle();
        exe_valid = 1'b0;
        mem_ack = 1'($urandom);
        mem_rdata = $urandom;
        @(negedge clk);
        mem_ack = 1'b0;
        $display("[TB] bubble");
        check_eq("bubble_pulses", {30'd0, wb_valid, mem_err}, 32'd0);
        check_eq("bubble_stall_req", {30'd0, stall, mem_req}, 32'd0);
    endtask

    initial begin
        int d;
        logic [31:0] a;
        rst = 1'b1; exe_valid = 1'b0; EXE_ReadfromMem = 1'b0; EXE_WritetoMem = 1'b0;
        EXE_R_memtoReg = 1'b0; exe_byte = 1'b0; exe_regwrite = 1'b0; exe_rd = '0;
        exe_addr = '0; exe_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        #2;
        $display("[TB] reset state");
        check_eq("rst_ctrl", {26'd0, stall, mem_req, mem_we, wb_valid, wb_regwrite, mem_err}, 32'd0);
        check_eq("rst_bus", mem_addr | mem_wdata | {28'd0, mem_be}, 32'd0);
        check_eq("rst_wb", wb_alu | wb_mdata | {27'd0, wb_rd} | {31'd0, wb_memtoReg}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        run_txn(1, 0, 1, 0, 1, 5'd3, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        run_txn(0, 1, 0, 1, 1, 5'd4, 32'h203, 32'h000000A5, 1, 32'h0);
        run_txn(1, 0, 1, 1, 1, 5'd6, 32'h302, 32'h0, 0, 32'h11223344);
        run_txn(0, 1, 0, 0, 1, 5'd7, 32'h102, 32'h12345678, 0, 32'h0);
        idle_cycle();
        run_txn(1, 0, 1, 0, 1, 5'd8, 32'h400, 32'h0, 99, 32'h0);
        run_txn(1, 0, 1, 0, 1, 5'd9, 32'h404, 32'h0, MAX_WAIT - 1, 32'hCAFEF00D);
        run_txn(1, 1, 1, 1, 1, 5'd10, 32'h500, 32'h0, 0, 32'h0);
        for (int i = 0; i < 4; i++)
            run_txn(0, 0, 0, 0, 1, 5'(i + 1), 32'h1000 + i, 32'h0, 0, 32'h0);
        idle_cycle();

        // Reset in the middle of an outstanding access.
        exe_valid = 1'b1; EXE_ReadfromMem = 1'b1; EXE_WritetoMem = 1'b0;
        exe_byte = 1'b0; exe_regwrite = 1'b1; exe_rd = 5'd12; exe_addr = 32'h600;
        @(negedge clk);
        exe_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        $display("[TB] reset mid-wait");
        check_eq("rstwait_req_stall", {30'd0, stall, mem_req}, 32'd0);
        check_eq("rstwait_wb", {30'd0, wb_valid, mem_err}, 32'd0);
        @(negedge clk);
        check_eq("rstwait_after", {29'd0, wb_valid, mem_err, stall}, 32'd0);
        rst = 1'b0;

        // Randomized mix.
        for (int i = 0; i < 60; i++) begin
            d = ($urandom_range(0, 7) == 0) ? $urandom_range(MAX_WAIT - 2, MAX_WAIT + 1)
                                             : $urandom_range(0, 4);
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            run_txn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    5'($urandom), a, $urandom, d, $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
